dccm_arbiter: RTL and testbench

DCCM_ARBITER -- requirements
Module: dccm_arbiter

---
 rtl/dccm_arbiter.sv | 131 +++++++++++++
 tb/tb_dccm_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_arbiter.sv
// dccm_arbiter: single-port DCCM arbitration between the LSU and a DMA master.
// The LSU wins by default. A DMA request refused STARVE_MAX cycles in a row
// is forced through, and the LSU is stalled for that cycle.
module dccm_arbiter #(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // LSU side
    input  logic          lsu_load_valid_i,
    input  logic          lsu_store_valid_i,
    input  logic [AW-1:0] lsu_addr_i,
    input  logic [31:0]   lsu_wdata_i,
    output logic          lsu_stall_o,
    output logic [31:0]   lsu_rd_data_o,
    // DMA side
    input  logic          dma_req_valid_i,
    output logic          dma_req_ready_o,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [31:0]   dma_wdata_i,
    output logic          dma_rsp_valid_o,
    output logic [31:0]   dma_rsp_data_o,
    // DCCM port
    output logic          dccm_wr_en_o,
    output logic          dccm_rd_en_o,
    output logic [AW-1:0] dccm_wr_addr_o,
    output logic [AW-1:0] dccm_rd_addr_o,
    output logic [31:0]   dccm_wr_data_o,
    input  logic [31:0]   dccm_rd_data_i
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LSU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t          rd_owner;
    owner_t          rd_owner_nxt;
    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_cnt_nxt;

    logic            lsu_req;
    logic            starved;
    logic            dma_grant;
    logic            lsu_grant;
    logic [AW-1:0]   dma_addr_aligned;

    assign lsu_req          = lsu_load_valid_i | lsu_store_valid_i;
    assign starved          = (starve_cnt == CW'(STARVE_MAX));
    assign dma_addr_aligned = {dma_addr_i[AW-1:2], 2'b00};

    // Grant decision; everything is held off while reset is asserted
    always_comb begin
        dma_grant = 1'b0;
        lsu_grant = 1'b0;
        if (rst_n) begin
            dma_grant = dma_req_valid_i & (~lsu_req | starved);
            lsu_grant = lsu_req & ~dma_grant;
        end
    end

    assign dma_req_ready_o = dma_grant;
    assign lsu_stall_o     = dma_grant & lsu_req;

    // DCCM port drive; idle address/data fields are forced to zero
    always_comb begin
        dccm_wr_en_o   = 1'b0;
        dccm_rd_en_o   = 1'b0;
        dccm_wr_addr_o = '0;
        dccm_rd_addr_o = '0;
        dccm_wr_data_o = '0;
        if (dma_grant) begin
            if (dma_we_i) begin
                dccm_wr_en_o   = 1'b1;
                dccm_wr_addr_o = dma_addr_aligned;
                dccm_wr_data_o = dma_wdata_i;
            end else begin
                dccm_rd_en_o   = 1'b1;
                dccm_rd_addr_o = dma_addr_aligned;
            end
        end else if (lsu_grant) begin
            // A store wins over a simultaneous load
            if (lsu_store_valid_i) begin
                dccm_wr_en_o   = 1'b1;
                dccm_wr_addr_o = lsu_addr_i;
                dccm_wr_data_o = lsu_wdata_i;
            end else begin
                dccm_rd_en_o   = 1'b1;
                dccm_rd_addr_o = lsu_addr_i;
            end
        end
    end

    // Next-state: read-data owner and DMA starvation counter
    always_comb begin
        rd_owner_nxt   = OWN_NONE;
        starve_cnt_nxt = '0;
        if (dma_grant && !dma_we_i) begin
            rd_owner_nxt = OWN_DMA;
        end else if (lsu_grant && !lsu_store_valid_i) begin
            rd_owner_nxt = OWN_LSU;
        end
        if (dma_req_valid_i && !dma_grant) begin
            starve_cnt_nxt = starved ? starve_cnt : starve_cnt + CW'(1);
        end
    end

    // State register; reset drops any read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner   <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            rd_owner   <= rd_owner_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Read-data steering from the registered owner
    always_comb begin
        dma_rsp_valid_o = (rd_owner == OWN_DMA);
        dma_rsp_data_o  = (rd_owner == OWN_DMA) ? dccm_rd_data_i : 32'h0;
        lsu_rd_data_o   = (rd_owner == OWN_LSU) ? dccm_rd_data_i : 32'h0;
    end

endmodule

// File: tb/tb_dccm_arbiter.sv
// tb_dccm_arbiter: directed tests for dccm_arbiter with hand-computed expectations.
module tb_dccm_arbiter;

    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst_n;
    logic          lsu_load_valid_i;
    logic          lsu_store_valid_i;
    logic [AW-1:0] lsu_addr_i;
    logic [31:0]   lsu_wdata_i;
    logic          lsu_stall_o;
    logic [31:0]   lsu_rd_data_o;
    logic          dma_req_valid_i;
    logic          dma_req_ready_o;
    logic          dma_we_i;
    logic [AW-1:0] dma_addr_i;
    logic [31:0]   dma_wdata_i;
    logic          dma_rsp_valid_o;
    logic [31:0]   dma_rsp_data_o;
    logic          dccm_wr_en_o;
    logic          dccm_rd_en_o;
    logic [AW-1:0] dccm_wr_addr_o;
    logic [AW-1:0] dccm_rd_addr_o;
    logic [31:0]   dccm_wr_data_o;
    logic [31:0]   dccm_rd_data_i;

    int errors = 0;
    int checks = 0;

    dccm_arbiter #(.STARVE_MAX(8), .AW(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lsu_load_valid_i  (lsu_load_valid_i),
        .lsu_store_valid_i (lsu_store_valid_i),
        .lsu_addr_i        (lsu_addr_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .lsu_stall_o       (lsu_stall_o),
        .lsu_rd_data_o     (lsu_rd_data_o),
        .dma_req_valid_i   (dma_req_valid_i),
        .dma_req_ready_o   (dma_req_ready_o),
        .dma_we_i          (dma_we_i),
        .dma_addr_i        (dma_addr_i),
        .dma_wdata_i       (dma_wdata_i),
        .dma_rsp_valid_o   (dma_rsp_valid_o),
        .dma_rsp_data_o    (dma_rsp_data_o),
        .dccm_wr_en_o      (dccm_wr_en_o),
        .dccm_rd_en_o      (dccm_rd_en_o),
        .dccm_wr_addr_o    (dccm_wr_addr_o),
        .dccm_rd_addr_o    (dccm_rd_addr_o),
        .dccm_wr_data_o    (dccm_wr_data_o),
        .dccm_rd_data_i    (dccm_rd_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        lsu_load_valid_i  = 1'b0;
        lsu_store_valid_i = 1'b0;
        lsu_addr_i        = '0;
        lsu_wdata_i       = '0;
        dma_req_valid_i   = 1'b0;
        dma_we_i          = 1'b0;
        dma_addr_i        = '0;
        dma_wdata_i       = '0;
        dccm_rd_data_i    = '0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n            = 1'b0;
        lsu_load_valid_i = 1'b1;
        lsu_addr_i       = 32'h40;
        dma_req_valid_i  = 1'b1;
        dma_addr_i       = 32'h80;
        dccm_rd_data_i   = 32'hA5A5_A5A5;
        step();
        step();
        #1;
        checks++; if (dma_req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b exp=0", dma_req_ready_o); end
        checks++; if (lsu_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", lsu_stall_o); end
        checks++; if ({dccm_wr_en_o, dccm_rd_en_o} !== 2'b00) begin errors++; $display("FAIL rst_en got=%b exp=00", {dccm_wr_en_o, dccm_rd_en_o}); end
        checks++; if ({dccm_wr_addr_o, dccm_rd_addr_o, dccm_wr_data_o} !== '0) begin errors++; $display("FAIL rst_addr_data got wa=%h ra=%h wd=%h exp=0", dccm_wr_addr_o, dccm_rd_addr_o, dccm_wr_data_o); end
        checks++; if (dma_rsp_valid_o !== 1'b0 || lsu_rd_data_o !== 32'h0) begin errors++; $display("FAIL rst_rsp got v=%0b ld=%h exp 0", dma_rsp_valid_o, lsu_rd_data_o); end
        checks++; if (dut.starve_cnt !== '0) begin errors++; $display("FAIL rst_starve got=%0d exp=0", dut.starve_cnt); end
        set_idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_dma_read();
        dma_req_valid_i = 1'b1;
        dma_we_i        = 1'b0;
        dma_addr_i      = 32'h104;
        #1;
        checks++; if (dma_req_ready_o !== 1'b1) begin errors++; $display("FAIL dmard_ready got=%0b exp=1", dma_req_ready_o); end
        checks++; if (dccm_rd_en_o !== 1'b1 || dccm_rd_addr_o !== 32'h104 || dccm_wr_en_o !== 1'b0) begin errors++; $display("FAIL dmard_port got rd=%0b ra=%h wr=%0b exp 1/104/0", dccm_rd_en_o, dccm_rd_addr_o, dccm_wr_en_o); end
        step();
        set_idle();
        dccm_rd_data_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b1 || dma_rsp_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dmard_rsp got v=%0b d=%h exp 1/deadbeef", dma_rsp_valid_o, dma_rsp_data_o); end
        checks++; if (lsu_rd_data_o !== 32'h0) begin errors++; $display("FAIL dmard_lsu_leak got=%h exp=0", lsu_rd_data_o); end
        step();
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b0 || dma_rsp_data_o !== 32'h0) begin errors++; $display("FAIL dmard_pulse got v=%0b d=%h exp 0/0", dma_rsp_valid_o, dma_rsp_data_o); end
        set_idle();
    endtask

    task automatic test_starvation();
        lsu_load_valid_i = 1'b1;
        lsu_addr_i       = 32'h40;
        dma_req_valid_i  = 1'b1;
        dma_we_i         = 1'b1;
        dma_addr_i       = 32'h80;
        dma_wdata_i      = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (dma_req_ready_o !== 1'b0 || lsu_stall_o !== 1'b0 || dccm_rd_en_o !== 1'b1 || dccm_rd_addr_o !== 32'h40) begin
                errors++;
                $display("FAIL starve_refuse[%0d] got rdy=%0b stall=%0b rd=%0b ra=%h exp 0/0/1/40", i, dma_req_ready_o, lsu_stall_o, dccm_rd_en_o, dccm_rd_addr_o);
            end
            step();
        end
        #1;
        checks++; if (dma_req_ready_o !== 1'b1 || lsu_stall_o !== 1'b1) begin errors++; $display("FAIL starve_grant got rdy=%0b stall=%0b exp 1/1", dma_req_ready_o, lsu_stall_o); end
        checks++; if (dccm_wr_en_o !== 1'b1 || dccm_rd_en_o !== 1'b0 || dccm_wr_addr_o !== 32'h80 || dccm_wr_data_o !== 32'h1234_5678) begin errors++; $display("FAIL starve_port got wr=%0b rd=%0b wa=%h wd=%h exp 1/0/80/12345678", dccm_wr_en_o, dccm_rd_en_o, dccm_wr_addr_o, dccm_wr_data_o); end
        step();
        dma_req_valid_i = 1'b0;
        #1;
        checks++; if (dut.starve_cnt !== '0) begin errors++; $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt); end
        checks++; if (lsu_stall_o !== 1'b0 || dccm_rd_en_o !== 1'b1) begin errors++; $display("FAIL starve_resume got stall=%0b rd=%0b exp 0/1", lsu_stall_o, dccm_rd_en_o); end
        step();
        set_idle();
        step();
    endtask

    task automatic test_load_store();
        lsu_load_valid_i  = 1'b1;
        lsu_store_valid_i = 1'b1;
        lsu_addr_i        = 32'h20;
        lsu_wdata_i       = 32'h0000_0055;
        #1;
        checks++; if (dccm_wr_en_o !== 1'b1 || dccm_wr_addr_o !== 32'h20 || dccm_wr_data_o !== 32'h55) begin errors++; $display("FAIL ldst_write got wr=%0b wa=%h wd=%h exp 1/20/55", dccm_wr_en_o, dccm_wr_addr_o, dccm_wr_data_o); end
        checks++; if (dccm_rd_en_o !== 1'b0 || dccm_rd_addr_o !== 32'h0) begin errors++; $display("FAIL ldst_noread got rd=%0b ra=%h exp 0/0", dccm_rd_en_o, dccm_rd_addr_o); end
        step();
        set_idle();
        dccm_rd_data_i = 32'hCAFE_F00D;
        #1;
        checks++; if (lsu_rd_data_o !== 32'h0 || dma_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL ldst_nodata got ld=%h v=%0b exp 0/0", lsu_rd_data_o, dma_rsp_valid_o); end
        set_idle();
    endtask

    task automatic test_dma_write_align();
        dma_req_valid_i = 1'b1;
        dma_we_i        = 1'b1;
        dma_addr_i      = 32'h0F;
        dma_wdata_i     = 32'hAAAA_5555;
        #1;
        checks++; if (dma_req_ready_o !== 1'b1 || dccm_wr_en_o !== 1'b1 || dccm_wr_addr_o !== 32'h0C) begin errors++; $display("FAIL dmawr_align got rdy=%0b wr=%0b wa=%h exp 1/1/0c", dma_req_ready_o, dccm_wr_en_o, dccm_wr_addr_o); end
        step();
        set_idle();
        dccm_rd_data_i = 32'h1111_2222;
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b0 || dma_rsp_data_o !== 32'h0) begin errors++; $display("FAIL dmawr_norsp got v=%0b d=%h exp 0/0", dma_rsp_valid_o, dma_rsp_data_o); end
        set_idle();
    endtask

    task automatic test_reset_mid_read();
        dma_req_valid_i = 1'b1;
        dma_we_i        = 1'b0;
        dma_addr_i      = 32'h300;
        #1;
        checks++; if (dma_req_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_grant got=%0b exp=1", dma_req_ready_o); end
        #1;
        rst_n = 1'b0;
        step();
        set_idle();
        dccm_rd_data_i = 32'h7777_8888;
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b0 || dma_rsp_data_o !== 32'h0) begin errors++; $display("FAIL midrst_rsp got v=%0b d=%h exp 0/0", dma_rsp_valid_o, dma_rsp_data_o); end
        step();
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_late got v=%0b exp=0", dma_rsp_valid_o); end
        // First edge after release must take a new request
        dma_req_valid_i = 1'b1;
        dma_addr_i      = 32'h8;
        #1;
        checks++; if (dma_req_ready_o !== 1'b1 || dccm_rd_addr_o !== 32'h8) begin errors++; $display("FAIL postrst_accept got rdy=%0b ra=%h exp 1/8", dma_req_ready_o, dccm_rd_addr_o); end
        step();
        set_idle();
        dccm_rd_data_i = 32'h0BAD_C0DE;
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b1 || dma_rsp_data_o !== 32'h0BAD_C0DE) begin errors++; $display("FAIL postrst_rsp got v=%0b d=%h exp 1/0badc0de", dma_rsp_valid_o, dma_rsp_data_o); end
        step();
        set_idle();
    endtask

    task automatic test_back_to_back();
        // Cycle A: LSU load
        lsu_load_valid_i = 1'b1;
        lsu_addr_i       = 32'h10;
        step();
        // Cycle B: DMA read; data now belongs to the LSU
        set_idle();
        dma_req_valid_i = 1'b1;
        dma_addr_i      = 32'h200;
        dccm_rd_data_i  = 32'h1111_1111;
        #1;
        checks++; if (lsu_rd_data_o !== 32'h1111_1111 || dma_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_lsu1 got ld=%h v=%0b exp 11111111/0", lsu_rd_data_o, dma_rsp_valid_o); end
        step();
        // Cycle C: LSU load; data belongs to the DMA
        set_idle();
        lsu_load_valid_i = 1'b1;
        lsu_addr_i       = 32'h14;
        dccm_rd_data_i   = 32'h2222_2222;
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b1 || dma_rsp_data_o !== 32'h2222_2222 || lsu_rd_data_o !== 32'h0) begin errors++; $display("FAIL b2b_dma1 got v=%0b d=%h ld=%h exp 1/22222222/0", dma_rsp_valid_o, dma_rsp_data_o, lsu_rd_data_o); end
        step();
        // Cycle D: DMA read again, then a second DMA read back-to-back
        set_idle();
        dma_req_valid_i = 1'b1;
        dma_addr_i      = 32'h204;
        dccm_rd_data_i  = 32'h3333_3333;
        #1;
        checks++; if (lsu_rd_data_o !== 32'h3333_3333 || dma_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_lsu2 got ld=%h v=%0b exp 33333333/0", lsu_rd_data_o, dma_rsp_valid_o); end
        step();
        dma_addr_i     = 32'h208;
        dccm_rd_data_i = 32'h4444_4444;
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b1 || dma_rsp_data_o !== 32'h4444_4444 || lsu_rd_data_o !== 32'h0) begin errors++; $display("FAIL b2b_dma2 got v=%0b d=%h ld=%h exp 1/44444444/0", dma_rsp_valid_o, dma_rsp_data_o, lsu_rd_data_o); end
        step();
        set_idle();
        dccm_rd_data_i = 32'h5555_5555;
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b1 || dma_rsp_data_o !== 32'h5555_5555) begin errors++; $display("FAIL b2b_dma3 got v=%0b d=%h exp 1/55555555", dma_rsp_valid_o, dma_rsp_data_o); end
        step();
        #1;
        checks++; if (dma_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%0b exp=0", dma_rsp_valid_o); end
    endtask

    // Test sequence
    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_dma_read();
        test_starvation();
        test_load_store();
        test_dma_write_align();
        test_reset_mid_read();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
